// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the three image-BRAM requesters, the arbiter and the BRAM port.
interface bram_port_arbiter_if;
  logic        ld_req_i;
  logic [17:0] ld_addr_i;
  logic [7:0]  ld_data_i;
  logic        ld_gnt_o;
  logic        ft_req_i;
  logic [17:0] ft_addr_i;
  logic        ft_gnt_o;
  logic        ft_rvalid_o;
  logic [7:0]  ft_rdata_o;
  logic        vg_req_i;
  logic [17:0] vg_addr_i;
  logic        vg_gnt_o;
  logic        vg_rvalid_o;
  logic [7:0]  vg_rdata_o;
  logic        ena_o;
  logic        wea_o;
  logic [17:0] addr_o;
  logic [7:0]  din_o;
  logic [7:0]  dout_i;
  logic        err_o;

  // Requester/BRAM side: drives requests and read data, observes everything else.
  modport master (
    output ld_req_i, ld_addr_i, ld_data_i, ft_req_i, ft_addr_i, vg_req_i, vg_addr_i, dout_i,
    input  ld_gnt_o, ft_gnt_o, ft_rvalid_o, ft_rdata_o, vg_gnt_o, vg_rvalid_o, vg_rdata_o,
           ena_o, wea_o, addr_o, din_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  ld_req_i, ld_addr_i, ld_data_i, ft_req_i, ft_addr_i, vg_req_i, vg_addr_i, dout_i,
    output ld_gnt_o, ft_gnt_o, ft_rvalid_o, ft_rdata_o, vg_gnt_o, vg_rvalid_o, vg_rdata_o,
           ena_o, wea_o, addr_o, din_o, err_o
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Single-port image BRAM arbiter: loader writes, fetch reads and VGA reads share one port.
// VGA wins unless it has held the port VGA_BURST cycles while others wait; loader and
// fetch alternate when both pend. Out-of-range accesses are granted but never reach the BRAM.
module bram_port_arbiter #(
  parameter int MAX_ROW   = 360,
  parameter int MAX_COL   = 540,
  parameter int READ_LAT  = 1,
  parameter int VGA_BURST = 8
) (
  input logic clk,
  input logic rst_n,
  bram_port_arbiter_if.slave bus
);

  localparam logic [17:0] DEPTH = 18'(MAX_ROW * MAX_COL);
  localparam int CW = $clog2(VGA_BURST + 1);
  localparam logic [CW-1:0] BURST = CW'(VGA_BURST);

  typedef enum logic {RR_LD, RR_FT} rr_e;

  rr_e                 rr_ptr;
  logic [CW-1:0]       vga_cnt;
  logic                g_ld, g_ft, g_vg;
  logic                any_gnt, others, oor;
  logic [17:0]         sel_addr;
  logic                iss_ft, iss_vg, iss_oor;
  logic [READ_LAT-1:0] p_ft, p_vg, p_oor;
  logic [7:0]          ft_hold, vg_hold, ret_data;
  logic                ena_q, wea_q, err_q;
  logic [17:0]         addr_q;
  logic [7:0]          din_q;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    g_ld   = 1'b0;
    g_ft   = 1'b0;
    g_vg   = 1'b0;
    others = bus.ld_req_i | bus.ft_req_i;
    if (rst_n) begin
      if (bus.vg_req_i && ((vga_cnt < BURST) || !others)) g_vg = 1'b1;
      else if (bus.ld_req_i && bus.ft_req_i) begin
        if (rr_ptr == RR_LD) g_ld = 1'b1;
        else                 g_ft = 1'b1;
      end
      else if (bus.ld_req_i) g_ld = 1'b1;
      else if (bus.ft_req_i) g_ft = 1'b1;
    end
  end

  assign any_gnt  = g_ld | g_ft | g_vg;
  assign sel_addr = g_ld ? bus.ld_addr_i : (g_ft ? bus.ft_addr_i : bus.vg_addr_i);
  assign oor      = any_gnt && (sel_addr >= DEPTH);

  // Round-robin pointer between loader/fetch and the VGA burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= RR_LD;
      vga_cnt <= '0;
    end else begin
      if (g_vg && others) begin
        if (vga_cnt != BURST) vga_cnt <= vga_cnt + CW'(1);
      end else begin
        vga_cnt <= '0;
      end
      if (g_ld)      rr_ptr <= RR_FT;
      else if (g_ft) rr_ptr <= RR_LD;
    end
  end

  // Registered BRAM port drive plus sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      iss_ft  <= 1'b0;
      iss_vg  <= 1'b0;
      iss_oor <= 1'b0;
    end else begin
      iss_ft  <= g_ft;
      iss_vg  <= g_vg;
      iss_oor <= oor;
      if (any_gnt) begin
        ena_q  <= !oor;
        wea_q  <= g_ld && !oor;
        addr_q <= sel_addr;
        din_q  <= g_ld ? bus.ld_data_i : 8'd0;
        if (oor) err_q <= 1'b1;
      end else begin
        ena_q <= 1'b0;
        wea_q <= 1'b0;
      end
    end
  end

  // Read tag pipe: the tag leaves the last stage in the cycle douta is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ft  <= '0;
      p_vg  <= '0;
      p_oor <= '0;
    end else begin
      p_ft[0]  <= iss_ft;
      p_vg[0]  <= iss_vg;
      p_oor[0] <= iss_oor;
      for (int i = 1; i < READ_LAT; i++) begin
        p_ft[i]  <= p_ft[i-1];
        p_vg[i]  <= p_vg[i-1];
        p_oor[i] <= p_oor[i-1];
      end
    end
  end

  // Out-of-range reads never touched the BRAM, so they return zero.
  assign ret_data = p_oor[READ_LAT-1] ? 8'd0 : bus.dout_i;

  // Last returned data per reader, so rdata holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ft_hold <= '0;
      vg_hold <= '0;
    end else begin
      if (p_ft[READ_LAT-1]) ft_hold <= ret_data;
      if (p_vg[READ_LAT-1]) vg_hold <= ret_data;
    end
  end

  assign bus.ld_gnt_o    = g_ld;
  assign bus.ft_gnt_o    = g_ft;
  assign bus.vg_gnt_o    = g_vg;
  assign bus.ft_rvalid_o = p_ft[READ_LAT-1];
  assign bus.vg_rvalid_o = p_vg[READ_LAT-1];
  assign bus.ft_rdata_o  = p_ft[READ_LAT-1] ? ret_data : ft_hold;
  assign bus.vg_rdata_o  = p_vg[READ_LAT-1] ? ret_data : vg_hold;
  assign bus.ena_o       = ena_q;
  assign bus.wea_o       = wea_q;
  assign bus.addr_o      = addr_q;
  assign bus.din_o       = din_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, rule-level reference model, directed and random stimulus.
module tb_bram_port_arbiter;
  localparam int DEPTH = 194400;
  localparam int VGB   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if bus ();

  bram_port_arbiter #(.MAX_ROW(360), .MAX_COL(540), .READ_LAT(1), .VGA_BURST(VGB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // BRAM model: unwritten locations read back as a ramp (addr & 0xFF), one cycle latency.
  bit [7:0] mem [0:262143];
  bit       wr  [0:262143];
  always @(posedge clk) begin
    if (bus.ena_o) begin
      if (bus.wea_o) begin
        mem[bus.addr_o] <= bus.din_o;
        wr[bus.addr_o]  <= 1'b1;
      end else begin
        bus.dout_i <= wr[bus.addr_o] ? mem[bus.addr_o] : bus.addr_o[7:0];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, expressed as the arbitration rules rather than RTL registers.
  typedef struct { int due; logic [7:0] d; } rd_t;
  rd_t         ft_q[$];
  rd_t         vg_q[$];
  logic [7:0]  shadow [int];
  int          cyc;
  int          pair_turn;   // 0: loader goes next when both wait, 1: fetch
  int          streak;      // VGA grants in a row while someone else waited
  logic        exp_ena, exp_wea, exp_err;
  logic [17:0] exp_addr;
  logic [7:0]  exp_din, last_ft, last_vg;
  logic [2:0]  act_last;
  bit          ft_hit;
  logic [7:0]  ft_hit_d;
  int          vg_hits;

  function automatic logic [7:0] ref_rd(input logic [17:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : a[7:0];
  endfunction

  task automatic model_reset();
    ft_q.delete();
    vg_q.delete();
    pair_turn = 0;
    streak    = 0;
    exp_ena   = 1'b0;
    exp_wea   = 1'b0;
    exp_err   = 1'b0;
    exp_addr  = '0;
    exp_din   = '0;
    last_ft   = '0;
    last_vg   = '0;
  endtask

  // One clock cycle: drive at negedge, check grants mid-low-phase, check registered side after posedge.
  task automatic step(input bit ld, input bit ft, input bit vg, input logic [17:0] la,
                      input logic [7:0] ldd, input logic [17:0] fa, input logic [17:0] va);
    logic [2:0]  exp_m;
    logic [17:0] a;
    bit          other, oor, ev;
    rd_t         r;
    bus.ld_req_i  = ld;
    bus.ft_req_i  = ft;
    bus.vg_req_i  = vg;
    bus.ld_addr_i = la;
    bus.ld_data_i = ldd;
    bus.ft_addr_i = fa;
    bus.vg_addr_i = va;
    #1;
    other = ld | ft;
    exp_m = 3'b000;
    if (vg && (streak < VGB || !other)) exp_m = 3'b100;
    else if (ld && ft)                  exp_m = (pair_turn == 0) ? 3'b001 : 3'b010;
    else if (ld)                        exp_m = 3'b001;
    else if (ft)                        exp_m = 3'b010;
    act_last = {bus.vg_gnt_o, bus.ft_gnt_o, bus.ld_gnt_o};
    check("grant", 32'(act_last), 32'(exp_m));
    if (exp_m == 3'b100) streak = other ? ((streak < VGB) ? streak + 1 : VGB) : 0;
    else                 streak = 0;
    if (exp_m == 3'b001) pair_turn = 1;
    if (exp_m == 3'b010) pair_turn = 0;
    if (exp_m != 3'b000) begin
      a        = exp_m[0] ? la : (exp_m[1] ? fa : va);
      oor      = int'(a) >= DEPTH;
      exp_ena  = !oor;
      exp_wea  = exp_m[0] && !oor;
      exp_addr = a;
      exp_din  = exp_m[0] ? ldd : 8'd0;
      if (oor) exp_err = 1'b1;
      if (exp_m[0] && !oor) shadow[int'(a)] = ldd;
      if (!exp_m[0]) begin
        r.due = cyc + 2;
        r.d   = oor ? 8'd0 : ref_rd(a);
        if (exp_m[1]) ft_q.push_back(r);
        else          vg_q.push_back(r);
      end
    end else begin
      exp_ena = 1'b0;
      exp_wea = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    check("ena", 32'(bus.ena_o), 32'(exp_ena));
    check("wea", 32'(bus.wea_o), 32'(exp_wea));
    check("addr", 32'(bus.addr_o), 32'(exp_addr));
    check("din", 32'(bus.din_o), 32'(exp_din));
    check("err", 32'(bus.err_o), 32'(exp_err));
    ev = ft_q.size() > 0 && ft_q[0].due == cyc;
    check("ft_rvalid", 32'(bus.ft_rvalid_o), 32'(ev));
    if (ev) begin
      last_ft  = ft_q[0].d;
      ft_hit   = 1'b1;
      ft_hit_d = bus.ft_rdata_o;
      void'(ft_q.pop_front());
    end
    check("ft_rdata", 32'(bus.ft_rdata_o), 32'(last_ft));
    ev = vg_q.size() > 0 && vg_q[0].due == cyc;
    check("vg_rvalid", 32'(bus.vg_rvalid_o), 32'(ev));
    if (ev) begin
      last_vg = vg_q[0].d;
      vg_hits++;
      void'(vg_q.pop_front());
    end
    check("vg_rdata", 32'(bus.vg_rdata_o), 32'(last_vg));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 18'd0, 8'd0, 18'd0, 18'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnts"}, 32'({bus.vg_gnt_o, bus.ft_gnt_o, bus.ld_gnt_o}), 32'd0);
    check({tag, "_port"}, 32'({bus.ena_o, bus.wea_o, bus.addr_o, bus.din_o}), 32'd0);
    check({tag, "_rv"}, 32'({bus.ft_rvalid_o, bus.vg_rvalid_o, bus.err_o}), 32'd0);
    check({tag, "_rdata"}, 32'({bus.ft_rdata_o, bus.vg_rdata_o}), 32'd0);
  endtask

  function automatic logic [17:0] rnd_addr();
    if ($urandom_range(0, 31) == 0) return 18'(DEPTH + $urandom_range(0, 1000));
    return 18'($urandom_range(0, 63));
  endfunction

  typedef struct { bit ld; bit ft; bit vg; logic [2:0] m; } vec_t;
  vec_t tbl[13];

  initial begin
    bit          r_ld, r_ft, r_vg;
    logic [17:0] r_la, r_fa, r_va;
    logic [7:0]  r_ld_d;

    // Expected grant masks {vg,ft,ld}, applied in order starting from the post-reset state.
    tbl[0]  = '{0, 0, 0, 3'b000};
    tbl[1]  = '{1, 0, 0, 3'b001};
    tbl[2]  = '{0, 1, 0, 3'b010};
    tbl[3]  = '{1, 1, 0, 3'b001};
    tbl[4]  = '{1, 1, 0, 3'b010};
    tbl[5]  = '{0, 0, 1, 3'b100};
    tbl[6]  = '{1, 0, 1, 3'b100};
    tbl[7]  = '{1, 1, 1, 3'b100};
    tbl[8]  = '{0, 1, 0, 3'b010};
    tbl[9]  = '{0, 1, 1, 3'b100};
    tbl[10] = '{1, 1, 0, 3'b001};
    tbl[11] = '{1, 1, 1, 3'b100};
    tbl[12] = '{1, 1, 0, 3'b010};

    cyc = 0;
    vg_hits = 0;
    ft_hit = 1'b0;
    ft_hit_d = '0;
    act_last = '0;
    model_reset();

    // Reset: all outputs zero, grants held off even with every request raised.
    bus.ld_req_i = 1'b1; bus.ft_req_i = 1'b1; bus.vg_req_i = 1'b1;
    bus.ld_addr_i = 18'd1; bus.ld_data_i = 8'h11; bus.ft_addr_i = 18'd2; bus.vg_addr_i = 18'd3;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // VGA streams one row; data must be the preloaded ramp, in order.
    for (int i = 0; i < 540; i++) step(1'b0, 1'b0, 1'b1, 18'd0, 8'd0, 18'd0, 18'(i));
    idle(2);
    check("t4_vg_count", 32'(vg_hits), 32'd540);

    // Loader writes 0xA5 at 5, fetch reads it back.
    step(1'b1, 1'b0, 1'b0, 18'd5, 8'hA5, 18'd0, 18'd0);
    idle(1);
    ft_hit = 1'b0;
    step(1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 18'd5, 18'd0);
    check("t1_ft_gnt", 32'(act_last), 32'(3'b010));
    idle(1);
    check("t1_ft_hit", 32'(ft_hit), 32'd1);
    check("t1_ft_data", 32'(ft_hit_d), 32'hA5);

    // Table-driven grant sequence.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ld, tbl[i].ft, tbl[i].vg, 18'(100 + i), 8'(3 * i), 18'(200 + i), 18'(300 + i));
      check($sformatf("tbl%0d", i), 32'(act_last), 32'(tbl[i].m));
    end
    idle(2);

    // Loader and fetch both held: strict alternation starting with the loader.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 18'(400 + i), 8'(i), 18'(500 + i), 18'd0);
      check($sformatf("t2_alt%0d", i), 32'(act_last), (i % 2 == 0) ? 32'b001 : 32'b010);
    end
    idle(2);

    // VGA and fetch held: 8 VGA grants, then one fetch, repeating; VGA alone every cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, 18'd0, 8'd0, 18'(600 + i), 18'(700 + i));
      check($sformatf("t3_burst%0d", i), 32'(act_last), ((i % 9) < 8) ? 32'b100 : 32'b010);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 18'd0, 8'd0, 18'd0, 18'(800 + i));
      check("t3_vg_alone", 32'(act_last), 32'b100);
    end
    idle(2);

    // Out-of-range fetch: granted, no BRAM access, sticky error, zero data.
    ft_hit = 1'b0;
    ft_hit_d = 8'hFF;
    step(1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 18'd194400, 18'd0);
    check("t5_gnt", 32'(act_last), 32'(3'b010));
    check("t5_ena", 32'(bus.ena_o), 32'd0);
    idle(1);
    check("t5_hit", 32'(ft_hit), 32'd1);
    check("t5_data", 32'(ft_hit_d), 32'd0);
    idle(3);
    check("t5_err_sticky", 32'(bus.err_o), 32'd1);

    // Randomized traffic with held requests until granted.
    r_ld = 0; r_ft = 0; r_vg = 0;
    r_la = '0; r_fa = '0; r_va = '0; r_ld_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!r_ld || act_last[0]) begin
        r_ld = $urandom_range(0, 99) < 45;
        r_la = rnd_addr();
        r_ld_d = 8'($urandom);
      end
      if (!r_ft || act_last[1]) begin
        r_ft = $urandom_range(0, 99) < 45;
        r_fa = rnd_addr();
      end
      if (!r_vg || act_last[2]) begin
        r_vg = $urandom_range(0, 99) < 70;
        r_va = rnd_addr();
      end
      step(r_ld, r_ft, r_vg, r_la, r_ld_d, r_fa, r_va);
    end
    idle(3);

    // Reset with one read in flight: everything clears, nothing returns afterwards.
    step(1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 18'd7, 18'd0);
    bus.ld_req_i = 1'b1; bus.ft_req_i = 1'b1; bus.vg_req_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(posedge clk);
    #1;
    check_all_zero("t6_rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(3);
    step(1'b1, 1'b1, 1'b0, 18'd20, 8'h3C, 18'd21, 18'd0);
    check("t6_rr_ld", 32'(act_last), 32'(3'b001));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
